// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state type, widths, S-box table,
// Rcon lookup and word helpers used by the key scheduler.
package aes_pkg;

    localparam int AES_KEY_W      = 128;
    localparam int AES_WORD_W     = 32;
    localparam int AES128_NROUNDS = 10;

    typedef enum logic {
        IDLE,
        EXPAND
    } state_e;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[8*(255-int'(b)) +: 8];
    endfunction

    // Indices past the last round return 0; the step result is
    // never consumed there.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        r = 8'h00;
        unique case (idx)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [AES_WORD_W-1:0] rot_word(
        input logic [AES_WORD_W-1:0] w
    );
        return {w[23:0], w[31:24]};
    endfunction

    // Word i of a key, word 0 in the top bits.
    function automatic logic [AES_WORD_W-1:0] key_word(
        input logic [AES_KEY_W-1:0] k,
        input int                   i
    );
        return k[AES_KEY_W-1-AES_WORD_W*i -: AES_WORD_W];
    endfunction

endpackage

// File: rtl/aes_key_sched_if.sv
// Key-load / round-key bus of the AES key scheduler.
// master: key source and round datapath; slave: aes_key_sched.
interface aes_key_sched_if;
    import aes_pkg::*;

    logic                 start;
    logic [AES_KEY_W-1:0] key;
    logic                 ready;
    logic                 busy;
    logic                 rk_valid;
    logic [3:0]           rk_idx;
    logic [AES_KEY_W-1:0] rk;
    logic                 done;
    logic [3:0]           rd_idx;
    logic [AES_KEY_W-1:0] rd_key;

    modport master (
        output start, key, rd_idx,
        input  ready, busy, rk_valid, rk_idx, rk, done, rd_key
    );

    modport slave (
        input  start, key, rd_idx,
        output ready, busy, rk_valid, rk_idx, rk, done, rd_key
    );

endinterface

// File: rtl/key_expand_step.sv
// One AES-128 key-expansion round, purely combinational.
// rk_in/rcon_idx -> rk_out; four S-boxes plus Rcon lookup.
module key_expand_step
    import aes_pkg::*;
(
    input  logic [AES_KEY_W-1:0] rk_in,
    input  logic [3:0]           rcon_idx,
    output logic [AES_KEY_W-1:0] rk_out
);

    logic [AES_WORD_W-1:0] w0, w1, w2, w3;
    logic [AES_WORD_W-1:0] rw, sw, t;
    logic [AES_WORD_W-1:0] n0, n1, n2, n3;
    logic [7:0]            rc;

    assign w0 = key_word(rk_in, 0);
    assign w1 = key_word(rk_in, 1);
    assign w2 = key_word(rk_in, 2);
    assign w3 = key_word(rk_in, 3);

    assign rw = rot_word(w3);
    assign rc = rcon(rcon_idx);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        assign sw[8*i +: 8] = sbox(rw[8*i +: 8]);
    end

    assign t  = sw ^ {rc, 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign rk_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES-128 key scheduler: one round key per clock, 0..10.
// Ports: clk, rst_n, bus (aes_key_sched_if.slave). Optional round-key
// store enabled by defining KEY_SCHED_RKMEM_EN.
module aes_key_sched
    import aes_pkg::*;
(
    input logic            clk,
    input logic            rst_n,
    aes_key_sched_if.slave bus
);

    state_e               state_q, state_d;
    logic [AES_KEY_W-1:0] rk_q, rk_d, rk_nxt;
    logic [3:0]           idx_q, idx_d;
    logic                 last;

    assign last = (state_q == EXPAND) &&
                  (idx_q == 4'(AES128_NROUNDS));

    key_expand_step u_step (
        .rk_in    (rk_q),
        .rcon_idx (idx_q),
        .rk_out   (rk_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rk_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = EXPAND;
                    rk_d    = bus.key;
                    idx_d   = '0;
                end
            end
            EXPAND: begin
                if (!last) begin
                    rk_d  = rk_nxt;
                    idx_d = idx_q + 4'd1;
                end else if (bus.start) begin
                    // back-to-back: next key follows with no gap
                    rk_d  = bus.key;
                    idx_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready    = (state_q == IDLE) || last;
    assign bus.busy     = (state_q == EXPAND);
    assign bus.rk_valid = (state_q == EXPAND);
    assign bus.rk_idx   = idx_q;
    assign bus.rk       = rk_q;
    assign bus.done     = last;

`ifdef KEY_SCHED_RKMEM_EN
    logic [AES_KEY_W-1:0] mem_q [0:AES128_NROUNDS];

    // Keeps every round key so decryption can walk them in reverse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= AES128_NROUNDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (state_q == EXPAND &&
                     idx_q <= 4'(AES128_NROUNDS)) begin
            mem_q[idx_q] <= rk_q;
        end
    end

    assign bus.rd_key = (bus.rd_idx <= 4'(AES128_NROUNDS)) ?
                        mem_q[bus.rd_idx] : '0;
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^bus.rd_idx;
    assign bus.rd_key    = '0;
`endif

endmodule

// File: tb/tb_aes_key_sched.sv
// Self-checking bench for aes_key_sched against a FIPS-197
// word-array key expansion model with a computed S-box.
module tb_aes_key_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    aes_key_sched_if bus ();

    aes_key_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total  = 0;
    int passed = 0;

    logic [7:0]   sb     [0:255];
    logic [127:0] exp_rk [0:10];
    logic [127:0] got    [0:10];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x,
                                         input int s);
        return (x << s) | (x >> (8 - s));
    endfunction

    // S-box from its definition: GF(2^8) inverse then affine map.
    task automatic build_sbox();
        logic [7:0] x;
        for (int v = 0; v < 256; v++) begin
            x = 8'h01;
            for (int j = 0; j < 254; j++) x = gmul(x, 8'(v));
            sb[v] = x ^ rotl8(x, 1) ^ rotl8(x, 2) ^
                    rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
        end
    endtask

    task automatic model(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]],
                     sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) begin
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic start_key(input logic [127:0] k);
        bus.key   = k;
        bus.start = 1'b1;
        step();
    endtask

    // Checks rounds 0..10 of key k; hold keeps start high and
    // loads nk on the last round; glitch pulses start with gk.
    task automatic check_seq(input logic [127:0] k,
                             input bit hold,
                             input logic [127:0] nk,
                             input bit glitch,
                             input logic [127:0] gk);
        model(k);
        for (int n = 0; n <= 10; n++) begin
            chk($sformatf("rk%0d", n), bus.rk, exp_rk[n]);
            chk($sformatf("idx%0d", n), 128'(bus.rk_idx), 128'(n));
            chk("valid", 128'(bus.rk_valid), 128'(1));
            chk("busy", 128'(bus.busy), 128'(1));
            chk($sformatf("done%0d", n), 128'(bus.done),
                128'(n == 10));
            chk($sformatf("ready%0d", n), 128'(bus.ready),
                128'(n == 10));
            got[n] = bus.rk;
            if (!hold) bus.start = glitch && (n == 5);
            if (glitch && n == 5) bus.key = gk;
            if (hold && n == 10) bus.key = nk;
            step();
        end
    endtask

    task automatic idle_chk();
        chk("idle_valid", 128'(bus.rk_valid), 128'(0));
        chk("idle_busy", 128'(bus.busy), 128'(0));
        chk("idle_ready", 128'(bus.ready), 128'(1));
        chk("idle_done", 128'(bus.done), 128'(0));
        chk("idle_rk", bus.rk, exp_rk[10]);
    endtask

    task automatic rkmem_chk();
`ifdef KEY_SCHED_RKMEM_EN
        for (int i = 0; i <= 10; i++) begin
            bus.rd_idx = 4'(i);
            #1;
            chk($sformatf("rd%0d", i), bus.rd_key, exp_rk[i]);
        end
        bus.rd_idx = 4'd15;
        #1;
        chk("rd15", bus.rd_key, 128'(0));
`else
        bus.rd_idx = 4'($urandom_range(0, 15));
        #1;
        chk("rd_off", bus.rd_key, 128'(0));
`endif
    endtask

    initial begin
        logic [127:0] ka, kb, kg;
        bus.start  = 1'b0;
        bus.key    = '0;
        bus.rd_idx = '0;
        build_sbox();

        step();
        chk("rst_ready", 128'(bus.ready), 128'(1));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_valid", 128'(bus.rk_valid), 128'(0));
        chk("rst_idx", 128'(bus.rk_idx), 128'(0));
        chk("rst_rk", bus.rk, 128'(0));
        chk("rst_done", 128'(bus.done), 128'(0));
        chk("rst_rd", bus.rd_key, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // FIPS-197 A.1
        ka = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        start_key(ka);
        check_seq(ka, 1'b0, '0, 1'b0, '0);
        chk("a1_rk1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("a1_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        idle_chk();
        rkmem_chk();

        // all-zero key
        start_key('0);
        check_seq('0, 1'b0, '0, 1'b0, '0);
        chk("z_rk1", got[1], 128'h62636363626363636263636362636363);
        chk("z_rk10", got[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        idle_chk();

        // back-to-back with start held high
        ka = rnd128();
        kb = rnd128();
        start_key(ka);
        check_seq(ka, 1'b1, kb, 1'b0, '0);
        bus.start = 1'b1;
        check_seq(kb, 1'b0, '0, 1'b0, '0);
        idle_chk();
        rkmem_chk();

        // start during expansion is ignored
        ka = rnd128();
        kg = rnd128();
        start_key(ka);
        check_seq(ka, 1'b0, '0, 1'b1, kg);
        idle_chk();

        // reset in the middle of an expansion
        ka = rnd128();
        model(ka);
        start_key(ka);
        bus.start = 1'b0;
        for (int n = 0; n <= 5; n++) begin
            chk($sformatf("pre_rst%0d", n), bus.rk, exp_rk[n]);
            if (n < 5) step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 128'(bus.busy), 128'(0));
        chk("arst_valid", 128'(bus.rk_valid), 128'(0));
        chk("arst_idx", 128'(bus.rk_idx), 128'(0));
        chk("arst_rk", bus.rk, 128'(0));
        chk("arst_ready", 128'(bus.ready), 128'(1));
        chk("arst_done", 128'(bus.done), 128'(0));
        bus.rd_idx = '0;
        #1;
        chk("arst_rd", bus.rd_key, 128'(0));
        step();
        chk("arst_done2", 128'(bus.done), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        kb = rnd128();
        start_key(kb);
        check_seq(kb, 1'b0, '0, 1'b0, '0);
        idle_chk();

        // random keys
        for (int r = 0; r < 4; r++) begin
            ka = rnd128();
            start_key(ka);
            check_seq(ka, 1'b0, '0, 1'b0, '0);
            idle_chk();
            rkmem_chk();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
